mdu: RTL

//   Iterative RV32M multiply/divide unit. It runs beside the single-cycle ALU in the execute stage.
//   It accepts one operation at a time over a valid/ready handshake and computes in a shift-add or

---
 rtl/mdu.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide, with a valid/ready request port and a held result port.
module mdu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_opsel,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_q, neg_r;
  logic [2*XLEN-1:0] prod;   // multiply: product; divide: low half = dividend/quotient
  logic [XLEN-1:0]   opb;    // multiply: multiplicand magnitude; divide: divisor magnitude
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   result;

  logic              accept, consume, is_div, s1, s2, special;
  logic [XLEN-1:0]   mag1, mag2, spec_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_s;
  logic [XLEN+1:0]   div_sh, div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   q_s, r_s, fix_res;

  assign o_ready  = (state == IDLE);
  assign o_valid  = (state == DONE);
  assign o_result = result;
  assign accept   = i_valid & o_ready;
  assign consume  = o_valid & i_ready;
  assign is_div   = i_opsel[2];

  always_comb begin
    s1       = 1'b0;
    s2       = 1'b0;
    special  = 1'b0;
    spec_res = '0;
    if (is_div) begin
      s1 = i_op1[XLEN-1] & ~i_opsel[0];
      s2 = i_op2[XLEN-1] & ~i_opsel[0];
      if (i_op2 == '0) begin
        special  = 1'b1;
        spec_res = i_opsel[1] ? i_op1 : '1;
      end else if (!i_opsel[0] && i_op1 == MIN_NEG && i_op2 == '1) begin
        special  = 1'b1;
        spec_res = i_opsel[1] ? '0 : i_op1;
      end
    end else begin
      s1 = i_op1[XLEN-1] & (i_opsel[1:0] != 2'b11);
      s2 = i_op2[XLEN-1] & ~i_opsel[1];
    end
    mag1 = s1 ? -i_op1 : i_op1;
    mag2 = s2 ? -i_op2 : i_op2;
  end

  always_comb begin
    mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, opb};
    mul_next = prod[0] ? {mul_sum, prod[XLEN-1:1]} : {1'b0, prod[2*XLEN-1:1]};
    div_sh   = {rem, prod[XLEN-1]};
    div_diff = div_sh - {2'b00, opb};
    div_ok   = ~div_diff[XLEN+1];
  end

  always_comb begin
    prod_s = neg_q ? -prod : prod;
    q_s    = neg_q ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    r_s    = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    if (op_q[2])
      fix_res = op_q[1] ? r_s : q_s;
    else if (op_q[1:0] == 2'b00)
      fix_res = prod_s[XLEN-1:0];
    else
      fix_res = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (consume) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      prod   <= '0;
      opb    <= '0;
      rem    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_q  <= i_opsel;
          neg_q <= s1 ^ s2;
          neg_r <= s1;
          cnt   <= CW'(XLEN-1);
          rem   <= '0;
          if (special) begin
            result <= spec_res;
          end else if (is_div) begin
            prod <= {{XLEN{1'b0}}, mag1};
            opb  <= mag2;
          end else begin
            prod <= {{XLEN{1'b0}}, mag2};
            opb  <= mag1;
          end
        end
        CALC: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          if (op_q[2]) begin
            rem  <= div_ok ? div_diff[XLEN:0] : div_sh[XLEN:0];
            prod <= {prod[2*XLEN-1:XLEN], prod[XLEN-2:0], div_ok};
          end else begin
            prod <= mul_next;
          end
        end
        FIX:  result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule
